spi_target: RTL and testbench
=============================

Name: spi_target

Overview:
- SPI mode-0 responder (target) for the j1a IO space; the far end of the bit-banged flash-style SPI master the CPU drives on its misc.out pins.
- Lets an external SPI master exchange bytes with the CPU.
- CPU-side handshake matches the UART: rd/wr strobes, valid/busy flags, 8-bit tx_data/rx_data.
- SCK, MOSI and CS_N are asynchronous to clk; they are synchronised and edge-detected internally, so there is no second clock domain.

Parameters:
- SYNC_STAGES, 2: flip-flop synchroniser depth on sck, mosi and cs_n (legal values 2..3).
- FILL, 8'hFF: byte shifted out when no tx byte has been queued.

Ports:
- clk  input  1  system clock.
- resetq  input  1  asynchronous active-low reset.
- sck  input  1  SPI clock from the external master (asynchronous).
- mosi  input  1  SPI data from the master (asynchronous).
- cs_n  input  1  SPI chip select, active low (asynchronous).
- miso  output  1  SPI data to the master.
- miso_oe  output  1  tri-state enable for miso; 1 while selected.
- rd  input  1  one-cycle CPU strobe; acknowledges rx_data.
- wr  input  1  one-cycle CPU strobe; queues tx_data.
- tx_data  input  8  byte to send.
- rx_data  output  8  last completed received byte.
- valid  output  1  rx_data is unread.
- busy  output  1  tx buffer is full.
- overrun  output  1  sticky flag: a byte completed while valid was already 1.
- selected  output  1  synchronised, inverted cs_n.

Behaviour:
- Reset values: miso=0, miso_oe=0, rx_data=0, valid=0, busy=0, overrun=0, selected=0. Bit counter=0, shift registers=0, tx buffer empty, state IDLE.
- Synchronisers: sck, mosi and cs_n each pass through SYNC_STAGES flops; cs_n resets to 1.
- Edge detection: one extra flop per signal; rise = cur & ~prev, fall = ~cur & prev.
- SCK limit: external SCK high and low times must each be >= SYNC_STAGES+2 clk cycles.
- State machine:
  - IDLE → ACTIVE on the synchronised cs_n falling edge.
  - ACTIVE → IDLE on the synchronised cs_n rising edge.
- IDLE: miso_oe=0. All sck edges are ignored.
- On entering ACTIVE:
  - bitcnt=0.
  - txshift loads the tx buffer if busy, else FILL; busy clears if it was set.
  - miso = bit 7 of the loaded byte from the next cycle onward; miso_oe=1.
- ACTIVE, sck rise: rxshift <= {rxshift[6:0], mosi_sync}; bitcnt increments modulo 8.
- Byte completion (sck rise with bitcnt==7):
  - rx_data <= {rxshift[6:0], mosi_sync} and valid <= 1 on the same clk edge.
  - If valid was already 1 and rd is not asserted that cycle: rx_data is overwritten and overrun <= 1.
  - Sets the pending reload flag.
- ACTIVE, sck fall:
  - Pending reload set: txshift loads the tx buffer (or FILL when not busy), busy clears, reload clears, miso = new bit 7.
  - Otherwise: txshift shifts left by 1 and miso = the new bit 7.
- rd: valid <= 0 on the next edge.
  - rd in the same cycle as a byte completion: completion wins; valid stays 1, no overrun.
  - rd does not clear overrun.
- Clearing overrun: only reset, or wr with tx_data==8'h00 while not busy and in IDLE. (This is a control write; it does not queue a byte.)
- wr while busy=0: the tx buffer captures tx_data and busy <= 1.
  - Exception: wr with tx_data==8'h00 while not busy and in IDLE is the overrun-clear write above and does not queue a byte.
- wr while busy=1: ignored; the buffer is unchanged.
- wr in the same cycle as a buffer consume:
  - The consume takes the old buffer contents (or FILL if the buffer was empty).
  - The new byte is then captured and busy=1.
- cs_n rises mid-byte:
  - Partial rx byte discarded; valid and rx_data unchanged.
  - bitcnt=0; reload flag cleared.
  - A tx byte already moved into txshift is lost.
  - A byte still held in the tx buffer is kept.
- Glitches: a cs_n pulse shorter than SYNC_STAGES cycles may be missed; no protection is required.
- Asynchronous reset mid-transfer: everything returns to reset values immediately, and the current frame is ignored until the next cs_n falling edge.

Test Plan:
- Receive: reset, master sends 8'hA5 at SCK = clk/10 → valid=1 and rx_data=8'hA5 within SYNC_STAGES+2 cycles of the 8th SCK rise; overrun=0. Then rd pulse → valid=0.
- Transmit: wr with tx_data=8'h3C before CS falls → busy=1. After CS falls, busy=0 and MISO bits sampled on SCK rises = 0,0,1,1,1,1,0,0. A second byte in the same frame returns FILL = 8'hFF.
- Back-to-back: queue 8'h11, master sends two bytes 8'h80,8'h01 in one frame; rd after byte 1; wr 8'h22 before byte 2 → master reads 8'h11 then 8'h22; CPU reads 8'h80 then 8'h01; overrun=0.
- Overrun: master sends 8'h55 then 8'hAA with no rd → rx_data=8'hAA, valid=1, overrun=1. rd → overrun stays 1. wr 8'h00 in IDLE → overrun=0.
- Abort: CS rises after 4 bits of 8'hF0 → valid unchanged and miso_oe=0. A new frame sending 8'h0F yields rx_data=8'h0F.
- Reset mid-frame: resetq low after 5 bits → all outputs at reset values immediately. After release, a full frame of 8'hC3 is received correctly.

Source files
------------

// File: rtl/spi_target.sv
// SPI mode-0 target for the j1a IO space.
// Pins are synchronised into clk; the CPU side uses UART-style strobes.
module spi_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] FILL        = 8'hFF
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       sck,
  input  logic       mosi,
  input  logic       cs_n,
  output logic       miso,
  output logic       miso_oe,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       valid,
  output logic       busy,
  output logic       overrun,
  output logic       selected
);

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_t;

  state_t r_state;

  logic [SYNC_STAGES-1:0] r_sck_s;
  logic [SYNC_STAGES-1:0] r_mosi_s;
  logic [SYNC_STAGES-1:0] r_cs_s;
  logic                   r_sck_prev;
  logic                   r_cs_prev;

  logic [2:0] r_bitcnt;
  logic [7:0] r_rxsh;
  logic [7:0] r_txsh;
  logic [7:0] r_buf;
  logic       r_reload;
  logic       r_miso;
  logic       r_miso_oe;
  logic [7:0] r_rx_data;
  logic       r_valid;
  logic       r_busy;
  logic       r_ovr;

  logic       w_sck;
  logic       w_mosi;
  logic       w_cs;
  logic       w_sck_rise;
  logic       w_sck_fall;
  logic       w_cs_rise;
  logic       w_cs_fall;
  logic       w_idle;
  logic       w_act;
  logic [7:0] w_load;
  logic       w_consume;
  logic       w_wr_ctl;
  logic       w_wr_q;
  logic       w_done;

  assign w_sck  = r_sck_s[SYNC_STAGES-1];
  assign w_mosi = r_mosi_s[SYNC_STAGES-1];
  assign w_cs   = r_cs_s[SYNC_STAGES-1];

  assign w_sck_rise = w_sck & ~r_sck_prev;
  assign w_sck_fall = ~w_sck & r_sck_prev;
  assign w_cs_rise  = w_cs & ~r_cs_prev;
  assign w_cs_fall  = ~w_cs & r_cs_prev;

  assign w_idle = (r_state == S_IDLE);
  assign w_act  = (r_state == S_ACTIVE);

  assign w_load = r_busy ? r_buf : FILL;

  // The buffer is drained at frame start and on the fall after a byte.
  assign w_consume = (w_idle & w_cs_fall) |
                     (w_act & ~w_cs_rise & w_sck_fall & r_reload);

  assign w_wr_ctl = wr & ~r_busy & w_idle & (tx_data == 8'h00);
  assign w_wr_q   = wr & ~w_wr_ctl & (~r_busy | w_consume);

  assign w_done = w_act & ~w_cs_rise & w_sck_rise & (r_bitcnt == 3'd7);

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_state    <= S_IDLE;
      r_sck_s    <= '0;
      r_mosi_s   <= '0;
      r_cs_s     <= '1;
      r_sck_prev <= 1'b0;
      r_cs_prev  <= 1'b1;
      r_bitcnt   <= 3'd0;
      r_rxsh     <= 8'h00;
      r_txsh     <= 8'h00;
      r_buf      <= 8'h00;
      r_reload   <= 1'b0;
      r_miso     <= 1'b0;
      r_miso_oe  <= 1'b0;
      r_rx_data  <= 8'h00;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_sck_s    <= {r_sck_s[SYNC_STAGES-2:0], sck};
      r_mosi_s   <= {r_mosi_s[SYNC_STAGES-2:0], mosi};
      r_cs_s     <= {r_cs_s[SYNC_STAGES-2:0], cs_n};
      r_sck_prev <= w_sck;
      r_cs_prev  <= w_cs;

      if (rd) r_valid <= 1'b0;
      if (w_wr_ctl) r_ovr <= 1'b0;

      if (w_wr_q) begin
        r_buf  <= tx_data;
        r_busy <= 1'b1;
      end else if (w_consume) begin
        r_busy <= 1'b0;
      end

      unique case (r_state)
        S_IDLE: begin
          r_miso_oe <= 1'b0;
          if (w_cs_fall) begin
            r_state   <= S_ACTIVE;
            r_bitcnt  <= 3'd0;
            r_reload  <= 1'b0;
            r_txsh    <= w_load;
            r_miso    <= w_load[7];
            r_miso_oe <= 1'b1;
          end
        end
        S_ACTIVE: begin
          if (w_cs_rise) begin
            r_state   <= S_IDLE;
            r_bitcnt  <= 3'd0;
            r_reload  <= 1'b0;
            r_rxsh    <= 8'h00;
            r_miso    <= 1'b0;
            r_miso_oe <= 1'b0;
          end else if (w_sck_rise) begin
            r_rxsh   <= {r_rxsh[6:0], w_mosi};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (w_done) begin
              r_rx_data <= {r_rxsh[6:0], w_mosi};
              r_valid   <= 1'b1;
              r_reload  <= 1'b1;
              if (r_valid && !rd) r_ovr <= 1'b1;
            end
          end else if (w_sck_fall) begin
            if (r_reload) begin
              r_txsh   <= w_load;
              r_miso   <= w_load[7];
              r_reload <= 1'b0;
            end else begin
              r_txsh <= {r_txsh[6:0], 1'b0};
              r_miso <= r_txsh[6];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign miso     = r_miso;
  assign miso_oe  = r_miso_oe;
  assign rx_data  = r_rx_data;
  assign valid    = r_valid;
  assign busy     = r_busy;
  assign overrun  = r_ovr;
  assign selected = ~w_cs;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: an SPI master model plus CPU strobes.
// SCK runs at clk/10; every expected value is written out by hand.
module tb_spi_target;

  logic       clk;
  logic       resetq;
  logic       sck;
  logic       mosi;
  logic       cs_n;
  logic       miso;
  logic       miso_oe;
  logic       rd;
  logic       wr;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       valid;
  logic       busy;
  logic       overrun;
  logic       selected;

  int n_run;
  int n_fail;

  logic [7:0] got;

  spi_target #(
    .SYNC_STAGES(2),
    .FILL(8'hFF)
  ) dut (
    .clk(clk),
    .resetq(resetq),
    .sck(sck),
    .mosi(mosi),
    .cs_n(cs_n),
    .miso(miso),
    .miso_oe(miso_oe),
    .rd(rd),
    .wr(wr),
    .tx_data(tx_data),
    .rx_data(rx_data),
    .valid(valid),
    .busy(busy),
    .overrun(overrun),
    .selected(selected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Leaves sck high after the last bit, so the reload fall
  // happens when the next byte (or the frame end) begins.
  task automatic xfer(input logic [7:0] tx,
                      input int nb,
                      output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      sck  = 1'b0;
      mosi = tx[7-i];
      repeat (5) @(negedge clk);
      rx  = {rx[6:0], miso};
      sck = 1'b1;
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic frame_start();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic frame_end();
    @(negedge clk);
    sck = 1'b0;
    repeat (5) @(negedge clk);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic cpu_wr(input logic [7:0] b);
    @(negedge clk);
    wr      = 1'b1;
    tx_data = b;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic cpu_rd();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " miso"}, {31'd0, miso}, 32'd0);
    chk({tag, " miso_oe"}, {31'd0, miso_oe}, 32'd0);
    chk({tag, " rx_data"}, {24'd0, rx_data}, 32'd0);
    chk({tag, " valid"}, {31'd0, valid}, 32'd0);
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " overrun"}, {31'd0, overrun}, 32'd0);
    chk({tag, " selected"}, {31'd0, selected}, 32'd0);
  endtask

  initial begin
    n_run   = 0;
    n_fail  = 0;
    resetq  = 1'b0;
    sck     = 1'b0;
    mosi    = 1'b0;
    cs_n    = 1'b1;
    rd      = 1'b0;
    wr      = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    resetq = 1'b1;
    repeat (5) @(negedge clk);

    // receive
    frame_start();
    chk("rx sel", {31'd0, selected}, 32'd1);
    chk("rx oe", {31'd0, miso_oe}, 32'd1);
    xfer(8'hA5, 8, got);
    chk("rx valid", {31'd0, valid}, 32'd1);
    chk("rx data", {24'd0, rx_data}, 32'hA5);
    chk("rx ovr", {31'd0, overrun}, 32'd0);
    chk("rx fill", {24'd0, got}, 32'hFF);
    cpu_rd();
    chk("rx rd", {31'd0, valid}, 32'd0);
    frame_end();
    chk("rx oe off", {31'd0, miso_oe}, 32'd0);

    // transmit
    cpu_wr(8'h3C);
    chk("tx busy", {31'd0, busy}, 32'd1);
    frame_start();
    chk("tx busy clr", {31'd0, busy}, 32'd0);
    xfer(8'h00, 8, got);
    chk("tx byte1", {24'd0, got}, 32'h3C);
    cpu_rd();
    xfer(8'h00, 8, got);
    chk("tx byte2", {24'd0, got}, 32'hFF);
    cpu_rd();
    frame_end();

    // back-to-back
    cpu_wr(8'h11);
    frame_start();
    xfer(8'h80, 8, got);
    chk("b2b m1", {24'd0, got}, 32'h11);
    chk("b2b c1", {24'd0, rx_data}, 32'h80);
    cpu_rd();
    cpu_wr(8'h22);
    chk("b2b busy", {31'd0, busy}, 32'd1);
    xfer(8'h01, 8, got);
    chk("b2b m2", {24'd0, got}, 32'h22);
    chk("b2b c2", {24'd0, rx_data}, 32'h01);
    chk("b2b ovr", {31'd0, overrun}, 32'd0);
    cpu_rd();
    frame_end();

    // overrun
    frame_start();
    xfer(8'h55, 8, got);
    xfer(8'hAA, 8, got);
    chk("ovr data", {24'd0, rx_data}, 32'hAA);
    chk("ovr valid", {31'd0, valid}, 32'd1);
    chk("ovr flag", {31'd0, overrun}, 32'd1);
    cpu_rd();
    chk("ovr rd valid", {31'd0, valid}, 32'd0);
    chk("ovr sticky", {31'd0, overrun}, 32'd1);
    frame_end();
    chk("ovr idle sel", {31'd0, selected}, 32'd0);
    cpu_wr(8'h00);
    chk("ovr clr", {31'd0, overrun}, 32'd0);
    chk("ovr clr busy", {31'd0, busy}, 32'd0);

    // abort
    frame_start();
    xfer(8'hF0, 4, got);
    frame_end();
    chk("abt valid", {31'd0, valid}, 32'd0);
    chk("abt data", {24'd0, rx_data}, 32'hAA);
    chk("abt oe", {31'd0, miso_oe}, 32'd0);
    frame_start();
    xfer(8'h0F, 8, got);
    chk("abt new", {24'd0, rx_data}, 32'h0F);
    chk("abt new valid", {31'd0, valid}, 32'd1);
    cpu_rd();
    frame_end();

    // reset mid-frame
    cpu_wr(8'h5A);
    frame_start();
    cpu_wr(8'h77);
    chk("mr busy", {31'd0, busy}, 32'd1);
    xfer(8'hFF, 5, got);
    @(negedge clk);
    resetq = 1'b0;
    #1;
    chk_reset_vals("mr");
    sck  = 1'b0;
    cs_n = 1'b1;
    repeat (5) @(negedge clk);
    resetq = 1'b1;
    repeat (5) @(negedge clk);
    frame_start();
    xfer(8'hC3, 8, got);
    chk("mr data", {24'd0, rx_data}, 32'hC3);
    chk("mr valid", {31'd0, valid}, 32'd1);
    chk("mr ovr", {31'd0, overrun}, 32'd0);
    chk("mr fill", {24'd0, got}, 32'hFF);
    frame_end();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
